fetch_queue: RTL and testbench

Instruction fetch stage and decoupling FIFO sitting directly upstream of the decode/control stage. Holds the PC and reads instruction memory one word per cycle. Buffers {pc, instr} pairs in a small circular queue and hands them to decode over a valid/ready handshake. The decoder consumes `out_instr[6:0]` as its opcode. A redirect (branch/jump resolution, pipeline flush) empties the queue and restarts fetch at a new PC.

---
 rtl/fetch_pkg.sv | 11 +
 rtl/fetch_queue_if.sv | 27 ++
 rtl/fetch_fifo.sv | 50 +++++
 rtl/fetch_queue.sv | 64 ++++++
 tb/tb_fetch_queue.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;
  localparam int          XLEN      = 32;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
  localparam int          PC_STEP   = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-side bundle: imem read port, redirect request and the decode handshake.
interface fetch_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_instr;
  logic [XLEN-1:0] out_pc;
  logic [CW-1:0]   count;

  modport master (
    output imem_addr, out_valid, out_instr, out_pc, count,
    input  imem_rdata, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_addr, out_valid, out_instr, out_pc, count,
    output imem_rdata, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// Circular buffer with push/pop/flush; count is the sole source of full/empty.
module fetch_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  pushData,
  input  logic          pop,
  output logic [W-1:0]  headData,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]           rdPtr, wrPtr;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign headData = mem[rdPtr];

  // Flush only rewinds the pointers; stale words stay hidden behind count == 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem   <= '0;
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else if (flush) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wrPtr] <= pushData;
        wrPtr      <= wrPtr + AW'(1);
      end
      if (pop)
        rdPtr <= rdPtr + AW'(1);
      if (push && !pop)
        count <= count + CW'(1);
      else if (pop && !push)
        count <= count - CW'(1);
    end
  end
endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: PC register, redirect priority and the decoupling queue to decode.
// Optional same-cycle bypass of an empty queue: define FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic            clk,
  input logic            rst,
  fetch_queue_if.master  fq
);
  import fetch_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = XLEN + 32;

  logic [XLEN-1:0] pc;
  logic            full, empty, push, fifoPush, fifoPop;
  logic [CW-1:0]   fifoCount;
  logic [EW-1:0]   headData;

  // Full blocks the fetch even when decode drains the head, so out_ready never reaches imem.
  assign push = !full && !fq.redirect_valid;

`ifdef FETCH_QUEUE_BYPASS_EN
  logic bypassHit;
  assign bypassHit    = empty && push;
  assign fq.out_valid = (!empty || bypassHit) && !fq.redirect_valid;
  assign fifoPush     = push && !(bypassHit && fq.out_ready);
  assign fq.out_instr = bypassHit ? fq.imem_rdata : headData[31:0];
  assign fq.out_pc    = bypassHit ? pc : headData[EW-1:32];
`else
  assign fq.out_valid = !empty && !fq.redirect_valid;
  assign fifoPush     = push;
  assign fq.out_instr = headData[31:0];
  assign fq.out_pc    = headData[EW-1:32];
`endif

  assign fifoPop      = !empty && fq.out_valid && fq.out_ready;
  assign fq.imem_addr = pc;
  assign fq.count     = fifoCount;

  always_ff @(posedge clk) begin
    if (rst)
      pc <= RESET_PC;
    else if (fq.redirect_valid)
      pc <= {fq.redirect_pc[XLEN-1:2], 2'b00};
    else if (push)
      pc <= pc + XLEN'(PC_STEP);
  end

  fetch_fifo #(.W(EW), .DEPTH(DEPTH)) uFifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (fq.redirect_valid),
    .push     (fifoPush),
    .pushData ({pc, fq.imem_rdata}),
    .pop      (fifoPop),
    .headData (headData),
    .full     (full),
    .empty    (empty),
    .count    (fifoCount)
  );
endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue against a queue-based reference model.
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_queue_if #(.XLEN(32), .DEPTH(DEPTH)) fq ();
  fetch_queue_if #(.XLEN(32), .DEPTH(DEPTH)) wq ();

  assign fq.imem_rdata     = fq.imem_addr ^ 32'hA5A5_0000;
  assign wq.imem_rdata     = wq.imem_addr ^ 32'hA5A5_0000;
  assign wq.redirect_valid = 1'b0;
  assign wq.redirect_pc    = 32'h0;
  assign wq.out_ready      = 1'b1;

  fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk (clk), .rst (rst), .fq (fq)
  );
  fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFFC)) dutWrap (
    .clk (clk), .rst (rst), .fq (wq)
  );

  int checks = 0;
  int errors = 0;
  bit mInit = 1'b0;
  bit drainChk = 1'b0;
  fetch_entry_t mq[$];
  logic [31:0] mPc;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: queue of fetched {pc, instr}; outputs derived from its head and the current inputs.
  always @(negedge clk) begin
    bit redir, push, expValid, byp;
    fetch_entry_t expE;
    if (rst) begin
      mq.delete();
      mPc   = 32'h0;
      mInit = 1'b1;
    end else if (mInit) begin
      redir    = fq.redirect_valid;
      push     = (mq.size() < DEPTH) && !redir;
      expValid = (mq.size() != 0) && !redir;
      byp      = 1'b0;
      expE     = '0;
      if (mq.size() != 0) expE = mq[0];
`ifdef FETCH_QUEUE_BYPASS_EN
      if (mq.size() == 0 && push) begin
        byp        = 1'b1;
        expValid   = 1'b1;
        expE.pc    = mPc;
        expE.instr = memWord(mPc);
      end
`endif
      chk("out_valid", {31'b0, fq.out_valid}, {31'b0, expValid});
      chk("count", {29'b0, fq.count}, 32'(mq.size()));
      chk("imem_addr", fq.imem_addr, mPc);
      if (expValid) begin
        chk("out_pc", fq.out_pc, expE.pc);
        chk("out_instr", fq.out_instr, expE.instr);
      end
      if (drainChk) chk("drain_count_le1", {31'b0, (fq.count <= 3'd1)}, 32'd1);

      if (redir) begin
        mq.delete();
        mPc = {fq.redirect_pc[31:2], 2'b00};
      end else begin
        if (expValid && fq.out_ready && !byp) void'(mq.pop_front());
        if (push && !(byp && fq.out_ready)) begin
          expE.pc    = mPc;
          expE.instr = memWord(mPc);
          mq.push_back(expE);
        end
        if (push) mPc = mPc + 32'd4;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int mode;
    fq.out_ready      = 1'b0;
    fq.redirect_valid = 1'b0;
    fq.redirect_pc    = 32'h0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

`ifndef FETCH_QUEUE_BYPASS_EN
    // C0: reset state
    @(negedge clk);
    chk("rst_out_valid", {31'b0, fq.out_valid}, 32'd0);
    chk("rst_out_instr", fq.out_instr, 32'h0);
    chk("rst_out_pc", fq.out_pc, 32'h0);
    chk("rst_count", {29'b0, fq.count}, 32'd0);
    chk("rst_imem_addr", fq.imem_addr, 32'h0);
    chk("wrap_rst_addr", wq.imem_addr, 32'hFFFF_FFFC);
    step(); @(negedge clk);  // C1
    chk("fill_addr1", fq.imem_addr, 32'h4);
    chk("wrap_pc0", wq.out_pc, 32'hFFFF_FFFC);
    chk("wrap_instr0", wq.out_instr, 32'h5A5A_FFFC);
    chk("wrap_addr1", wq.imem_addr, 32'h0);
    step(); @(negedge clk);  // C2
    chk("wrap_pc1", wq.out_pc, 32'h0);
    step(); step(); step(); @(negedge clk);  // C5
    chk("full_addr", fq.imem_addr, 32'h10);
    chk("full_count", {29'b0, fq.count}, 32'd4);
    chk("full_valid", {31'b0, fq.out_valid}, 32'd1);
    chk("full_pc", fq.out_pc, 32'h0);
    step(); fq.out_ready = 1'b1; @(negedge clk);  // C6: pop, no push
    chk("pop_count", {29'b0, fq.count}, 32'd4);
    step(); fq.out_ready = 1'b0; @(negedge clk);  // C7
    chk("bubble_count", {29'b0, fq.count}, 32'd3);
    chk("bubble_addr", fq.imem_addr, 32'h10);
    chk("bubble_pc", fq.out_pc, 32'h4);
    step(); @(negedge clk);  // C8
    chk("refill_count", {29'b0, fq.count}, 32'd4);
    chk("refill_addr", fq.imem_addr, 32'h14);
    step(); fq.out_ready = 1'b1;  // C9
    step(); fq.out_ready = 1'b0; fq.redirect_valid = 1'b1; fq.redirect_pc = 32'h0000_0103;
    @(negedge clk);  // C10
    chk("redir_count", {29'b0, fq.count}, 32'd3);
    chk("redir_valid", {31'b0, fq.out_valid}, 32'd0);
    step(); fq.redirect_valid = 1'b0; @(negedge clk);  // C11
    chk("redir_flush_count", {29'b0, fq.count}, 32'd0);
    chk("redir_addr", fq.imem_addr, 32'h100);
    chk("redir_nvalid", {31'b0, fq.out_valid}, 32'd0);
    step(); @(negedge clk);  // C12
    chk("redir_first_valid", {31'b0, fq.out_valid}, 32'd1);
    chk("redir_first_pc", fq.out_pc, 32'h100);
    chk("redir_first_instr", fq.out_instr, 32'hA5A5_0100);
`endif

    // reset and redirect together: reset wins
    step(); rst = 1'b1; fq.redirect_valid = 1'b1; fq.redirect_pc = 32'h500; fq.out_ready = 1'b1;
    step(); rst = 1'b0; fq.redirect_valid = 1'b0; drainChk = 1'b1;
    @(negedge clk);
    chk("rstwin_addr", fq.imem_addr, 32'h0);
    chk("rstwin_count", {29'b0, fq.count}, 32'd0);
`ifndef FETCH_QUEUE_BYPASS_EN
    step(); @(negedge clk);
    chk("drain_pc0", fq.out_pc, 32'h0);
    chk("drain_instr0", fq.out_instr, 32'hA5A5_0000);
    step(); @(negedge clk);
    chk("drain_pc1", fq.out_pc, 32'h4);
    chk("drain_instr1", fq.out_instr, 32'hA5A5_0004);
`endif
    repeat (20) step();
    drainChk = 1'b0;

    mode = 50;
    for (int i = 0; i < 3000; i++) begin
      int r;
      step();
      if (i % 100 == 0) mode = (i % 300 == 0) ? 10 : ((i % 200 == 0) ? 95 : 50);
      r = $urandom_range(0, 199);
      rst               = (r < 1);
      fq.redirect_valid = (r >= 1 && r < 11);
      fq.redirect_pc    = $urandom;
      fq.out_ready      = ($urandom_range(0, 99) < mode);
    end
    step(); rst = 1'b0; fq.redirect_valid = 1'b0;
    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
